// File: rtl/haar_pkg.sv
// Shared constants, FSM state encoding and accumulator width helper for the
// parameterised Haar-feature classifier.
package haar_pkg;

    localparam int unsigned N_POINTS_DEF   = 8;
    localparam int unsigned DATA_W_DEF     = 21;
    localparam int unsigned ADDR_W_DEF     = 15;
    localparam int unsigned WEIGHT_W_DEF   = 3;
    localparam int unsigned RD_LATENCY_DEF = 3;

    // Point index / table depth: cfg_idx is 4 bits, so at most 16 points.
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned TBL_DEPTH = 16;
    localparam int unsigned ACC_GUARD = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned weight_w);
        return data_w + weight_w + ACC_GUARD;
    endfunction

endpackage

// File: rtl/haar_rd_pipe.sv
// Valid/index shift pipeline that tags read data returning DEPTH cycles
// after each issued read address.
module haar_rd_pipe
    import haar_pkg::*;
#(
    parameter int unsigned DEPTH = RD_LATENCY_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [DEPTH-1:0] vld;
    logic [IDX_W-1:0] idx [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                idx[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            idx[0] <= in_idx;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_idx   = idx[DEPTH-1];

endmodule

// File: rtl/haar_classifier_param.sv
// Haar-feature classifier: issues N_POINTS weighted integral-image reads,
// accumulates the score and compares it to a threshold.
// Optional threshold adjustment is enabled by macro HAAR_THR_ADJUST_EN.
module haar_classifier_param
    import haar_pkg::*;
#(
    parameter int unsigned N_POINTS   = N_POINTS_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned WEIGHT_W   = WEIGHT_W_DEF,
    parameter int unsigned RD_LATENCY = RD_LATENCY_DEF,
    parameter int          THR_INIT   = 500,
    parameter int          THR_STEP   = 100,
    localparam int unsigned ACC_W     = acc_width(DATA_W, WEIGHT_W)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [IDX_W-1:0]           cfg_idx,
    input  logic [ADDR_W-1:0]          cfg_offset,
    input  logic signed [WEIGHT_W-1:0] cfg_weight,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_en,
    input  logic signed [DATA_W-1:0]   data_in,
    input  logic                       inc_thr,
    input  logic                       dec_thr,
    output logic signed [ACC_W-1:0]    threshold,
    output logic signed [ACC_W-1:0]    score,
    output logic                       detected
);

    localparam int unsigned PROD_W = DATA_W + WEIGHT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

    logic [1:0]                 state;
    logic [1:0]                 state_next;
    logic [ADDR_W-1:0]          base_q;
    logic [IDX_W-1:0]           issue_cnt;
    logic [ADDR_W-1:0]          offset_tbl [TBL_DEPTH];
    logic signed [WEIGHT_W-1:0] weight_tbl [TBL_DEPTH];
    logic signed [ACC_W-1:0]    acc;
    logic                       pipe_valid;
    logic [IDX_W-1:0]           pipe_idx;
    logic                       issue_c;
    logic                       start_c;
    logic                       cfg_ok_c;
    logic signed [PROD_W-1:0]   prod_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue_c    = (state == ST_ISSUE);
        start_c    = (state == ST_IDLE) && start;
        cfg_ok_c   = (state == ST_IDLE) && cfg_we && (32'(cfg_idx) < N_POINTS);
        case (state)
            ST_IDLE:  if (start) state_next = ST_ISSUE;
            ST_ISSUE: if (issue_cnt == LAST_IDX) state_next = ST_DRAIN;
            ST_DRAIN: if (pipe_valid && (pipe_idx == LAST_IDX)) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    haar_rd_pipe #(
        .DEPTH(RD_LATENCY)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (issue_c),
        .in_idx   (issue_cnt),
        .out_valid(pipe_valid),
        .out_idx  (pipe_idx)
    );

    assign prod_c = PROD_W'(data_in) * PROD_W'(weight_tbl[pipe_idx]);

    // Read issue, accumulation and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            base_q    <= '0;
            issue_cnt <= '0;
            acc       <= '0;
            score     <= '0;
            detected  <= 1'b0;
        end else begin
            busy  <= (state_next != ST_IDLE);
            done  <= (state == ST_DONE);
            rd_en <= issue_c;
            if (issue_c) begin
                rd_addr   <= base_q + offset_tbl[issue_cnt];
                issue_cnt <= issue_cnt + IDX_W'(1);
            end
            if (start_c) begin
                base_q    <= base_addr;
                issue_cnt <= '0;
                acc       <= '0;
            end else if (pipe_valid) begin
                acc <= acc + ACC_W'(prod_c);
            end
            if (state == ST_DONE) begin
                score    <= acc;
                detected <= (acc > threshold);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(TBL_DEPTH); i++) begin
                offset_tbl[i] <= '0;
                weight_tbl[i] <= '0;
            end
        end else if (cfg_ok_c) begin
            offset_tbl[cfg_idx] <= cfg_offset;
            weight_tbl[cfg_idx] <= cfg_weight;
        end
    end

`ifdef HAAR_THR_ADJUST_EN
    // Adjust in a one-bit-wider domain so the saturation test cannot overflow.
    localparam logic signed [ACC_W:0] THR_MAX  = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] THR_MIN  = -THR_MAX;
    localparam logic signed [ACC_W:0] STEP_EXT = (ACC_W+1)'(THR_STEP);

    logic signed [ACC_W:0] thr_ext_c;
    logic signed [ACC_W:0] thr_up_c;
    logic signed [ACC_W:0] thr_dn_c;

    always_comb begin
        thr_ext_c = (ACC_W+1)'(threshold);
        thr_up_c  = thr_ext_c + STEP_EXT;
        thr_dn_c  = thr_ext_c - STEP_EXT;
        if (thr_up_c > THR_MAX) thr_up_c = THR_MAX;
        if (thr_dn_c < THR_MIN) thr_dn_c = THR_MIN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            threshold <= ACC_W'(THR_INIT);
        end else if ((state == ST_IDLE) && (inc_thr ^ dec_thr)) begin
            threshold <= inc_thr ? ACC_W'(thr_up_c) : ACC_W'(thr_dn_c);
        end
    end
`else
    logic unused_thr_adj;
    assign unused_thr_adj = inc_thr ^ dec_thr;

    always_ff @(posedge clk) begin
        threshold <= ACC_W'(THR_INIT);
    end
`endif

endmodule

// File: tb/tb_haar_classifier_param.sv
// Randomised self-checking bench for haar_classifier_param against an
// arithmetic reference model (weighted sum of addressed samples).
module tb_haar_classifier_param;

    localparam int NP  = 8;
    localparam int LAT = 12;
    localparam logic signed [20:0] JUNK = 21'sh0AAAA;
`ifdef HAAR_THR_ADJUST_EN
    localparam longint THR_AFTER3 = 800;
`else
    localparam longint THR_AFTER3 = 500;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic               rst_n, cfg_we, start, inc_thr, dec_thr;
    logic [3:0]         cfg_idx;
    logic [14:0]        cfg_offset, base_addr, rd_addr;
    logic signed [2:0]  cfg_weight;
    logic               busy, done, rd_en, detected;
    logic signed [20:0] data_in;
    logic signed [27:0] threshold, score;

    haar_classifier_param u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_offset(cfg_offset), .cfg_weight(cfg_weight), .base_addr(base_addr),
        .start(start), .busy(busy), .done(done), .rd_addr(rd_addr), .rd_en(rd_en),
        .data_in(data_in), .inc_thr(inc_thr), .dec_thr(dec_thr),
        .threshold(threshold), .score(score), .detected(detected)
    );

    // Second configuration: four points, single-cycle read latency.
    logic               cfg_we4, start4, busy4, done4, rd_en4, detected4;
    logic [3:0]         cfg_idx4;
    logic [14:0]        cfg_offset4, rd_addr4;
    logic signed [2:0]  cfg_weight4;
    logic signed [20:0] data_in4;
    logic signed [27:0] threshold4, score4;

    assign data_in4 = 21'sd100;

    haar_classifier_param #(.N_POINTS(4), .RD_LATENCY(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we4), .cfg_idx(cfg_idx4),
        .cfg_offset(cfg_offset4), .cfg_weight(cfg_weight4), .base_addr(15'h0040),
        .start(start4), .busy(busy4), .done(done4), .rd_addr(rd_addr4), .rd_en(rd_en4),
        .data_in(data_in4), .inc_thr(1'b0), .dec_thr(1'b0),
        .threshold(threshold4), .score(score4), .detected(detected4)
    );

    // Memory model with three-cycle read latency.
    logic signed [20:0] mem [0:32767];
    logic signed [20:0] rd_data_c;
    logic signed [20:0] dpipe0, dpipe1;
    assign rd_data_c = rd_en ? mem[rd_addr] : JUNK;
    always @(posedge clk) begin
        dpipe0 <= rd_data_c;
        dpipe1 <= dpipe0;
    end
    assign data_in = dpipe1;

    logic [14:0] off_m [NP];
    int          w_m   [NP];
    longint      thr_m;
    longint      prev_score;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NP; k++) begin
            off_m[k] = '0;
            w_m[k]   = 0;
        end
        thr_m      = 500;
        prev_score = 0;
    endtask

    task automatic cfg_write(input int idx, input logic [14:0] off, input logic signed [2:0] w);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_offset = off; cfg_weight = w;
        @(negedge clk);
        cfg_we = 1'b0;
        if (idx < NP) begin
            off_m[idx] = off;
            w_m[idx]   = int'(w);
        end
    endtask

    task automatic thr_pulse(input bit inc, input bit dec);
        @(negedge clk);
        inc_thr = inc; dec_thr = dec;
        @(negedge clk);
        inc_thr = 1'b0; dec_thr = 1'b0;
`ifdef HAAR_THR_ADJUST_EN
        if (inc != dec) thr_m = thr_m + (inc ? 100 : -100);
        if (thr_m >  134217727) thr_m =  134217727;
        if (thr_m < -134217727) thr_m = -134217727;
`endif
        check("threshold", threshold, thr_m);
    endtask

    task automatic fill_mem(input logic [14:0] base);
        logic [14:0] a;
        for (int k = 0; k < NP; k++) begin
            a = base + off_m[k];
            mem[a] = 21'($urandom);
        end
    endtask

    task automatic run_op(input logic [14:0] base, input bit restart, input bit cfg_busy,
                          output logic [14:0] first_addr);
        longint             sum;
        logic signed [27:0] es;
        logic [14:0]        ea;
        int                 t, done_cyc, ndone, naddr;
        sum = 0;
        for (int k = 0; k < NP; k++) begin
            ea  = base + off_m[k];
            sum = sum + longint'(mem[ea]) * longint'(w_m[k]);
        end
        es = 28'(sum);
        first_addr = '0;
        @(negedge clk);
        base_addr = base; start = 1'b1; t = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("score_hold", score, prev_score);
        ndone = 0; done_cyc = -1; naddr = 0;
        for (int c = t; c <= t + LAT + 4; c++) begin
            if (rd_en) begin
                if (naddr < NP) begin
                    ea = base + off_m[naddr];
                    if (naddr == 0) first_addr = rd_addr;
                    check("rd_cycle", c, t + 1 + naddr);
                    check("rd_addr", rd_addr, ea);
                end
                naddr++;
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    check("score", score, es);
                    check("detected", detected, longint'(es) > thr_m);
                end
            end
            if (restart && c == t + 1) begin
                start = 1'b1; base_addr = ~base; inc_thr = 1'b1;
            end
            if (cfg_busy && c == t + 1) begin
                cfg_we = 1'b1; cfg_idx = 4'd0; cfg_offset = ~off_m[0];
                cfg_weight = 3'(~w_m[0]);
            end
            if (c == t + 2) begin
                start = 1'b0; inc_thr = 1'b0; cfg_we = 1'b0;
            end
            @(negedge clk);
        end
        check("rd_count", naddr, NP);
        check("done_count", ndone, 1);
        check("done_latency", done_cyc - t, LAT);
        check("score_after", score, es);
        check("busy_after", busy, 0);
        prev_score = es;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [14:0] fa;
        logic [14:0] b;
        int          w31 [NP];
        int          t4, d4, nd4;
        w31 = '{1, -1, -1, 1, -2, 2, 2, -2};
        rst_n = 1'b0; cfg_we = 1'b0; start = 1'b0; inc_thr = 1'b0; dec_thr = 1'b0;
        cfg_idx = '0; cfg_offset = '0; cfg_weight = '0; base_addr = '0;
        cfg_we4 = 1'b0; start4 = 1'b0; cfg_idx4 = '0; cfg_offset4 = '0; cfg_weight4 = '0;
        clear_model();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_score", score, 0);
        check("rst_detected", detected, 0);
        check("rst_threshold", threshold, 500);
        rst_n = 1'b1;

        // Three-rectangle feature: weighted sum cancels to zero.
        for (int k = 0; k < NP; k++) cfg_write(k, 15'(k * 256), 3'(w31[k]));
        for (int k = 0; k < NP; k++) mem[15'(15'h0100 + k * 256)] = 21'(10 * (k + 1));
        run_op(15'h0100, 1'b0, 1'b0, fa);
        check("req031_score", score, 0);
        check("req031_detected", detected, 0);

        // Address wrap.
        cfg_write(0, 15'h0020, 3'sd1);
        fill_mem(15'h7FF0);
        run_op(15'h7FF0, 1'b0, 1'b0, fa);
        check("wrap_addr", fa, 15'h0010);

        // Start, cfg and threshold requests while busy are ignored.
        fill_mem(15'h1234);
        run_op(15'h1234, 1'b1, 1'b1, fa);

        thr_pulse(1'b1, 1'b0);
        thr_pulse(1'b1, 1'b0);
        thr_pulse(1'b1, 1'b0);
        check("thr_after3", threshold, THR_AFTER3);
        thr_pulse(1'b1, 1'b1);
        check("thr_both", threshold, THR_AFTER3);
        thr_pulse(1'b0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < NP; k++) cfg_write(k, 15'($urandom), 3'($urandom));
            if (i % 3 == 0) cfg_write(8 + int'($urandom_range(0, 7)), 15'($urandom), 3'($urandom));
            b = 15'($urandom);
            fill_mem(b);
            run_op(b, (i % 5) == 2, (i % 4) == 1, fa);
        end

        // Reset in the second ISSUE cycle aborts without a done pulse.
        begin
            int t;
            @(negedge clk);
            base_addr = 15'h0555; start = 1'b1; t = cyc + 1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            check("mid_rst_busy", busy, 0);
            check("mid_rst_rd_en", rd_en, 0);
            check("mid_rst_rd_addr", rd_addr, 0);
            check("mid_rst_score", score, 0);
            check("mid_rst_thr", threshold, 500);
            check("mid_rst_cycle", cyc, t + 2);
            rst_n = 1'b1;
            clear_model();
            nd4 = 0;
            for (int c = 0; c < 20; c++) begin
                if (done) nd4++;
                @(negedge clk);
            end
            check("mid_rst_no_done", nd4, 0);
        end
        fill_mem(15'h0321);
        run_op(15'h0321, 1'b0, 1'b0, fa);
        check("cleared_table_score", score, 0);

        // Four-point configuration, weights all +1, data 100.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cfg_we4 = 1'b1; cfg_idx4 = 4'(k); cfg_offset4 = 15'(k); cfg_weight4 = 3'sd1;
            @(negedge clk);
            cfg_we4 = 1'b0;
        end
        @(negedge clk);
        start4 = 1'b1; t4 = cyc + 1;
        @(negedge clk);
        start4 = 1'b0;
        d4 = -1; nd4 = 0;
        for (int c = 0; c < 20; c++) begin
            if (done4) begin
                nd4++;
                if (d4 < 0) d4 = cyc;
            end
            @(negedge clk);
        end
        check("n4_done_count", nd4, 1);
        check("n4_latency", d4 - t4, 6);
        check("n4_score", score4, 400);
        check("n4_detected", detected4, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/haar_classifier_param.md
HAAR_CLASSIFIER_PARAM -- requirements
Module: haar_classifier_param

Interface
REQ-001 SHALL have parameter N_POINTS, default 8, number of integral-image sample points per feature, range 2..16.
REQ-002 SHALL have parameter DATA_W, default 21, signed integral-image sample width.
REQ-003 SHALL have parameter ADDR_W, default 15, buffer address width.
REQ-004 SHALL have parameter WEIGHT_W, default 3, signed per-point weight width.
REQ-005 SHALL have parameter RD_LATENCY, default 3, cycles from rd_addr to valid data_in, range 1..7.
REQ-006 SHALL have parameters THR_INIT (default 500) and THR_STEP (default 100), threshold reset value and adjust step.
REQ-007 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-008 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-009 SHALL have ports cfg_we (in, 1), cfg_idx (in, 4), cfg_offset (in, ADDR_W), cfg_weight (in, WEIGHT_W), which write point offset/weight table entry cfg_idx.
REQ-010 SHALL have port base_addr, input, ADDR_W, window origin, sampled on start.
REQ-011 SHALL have ports start (in, 1), busy (out, 1), done (out, 1, one-cycle pulse).
REQ-012 SHALL have ports rd_addr (out, ADDR_W), rd_en (out, 1), data_in (in, signed DATA_W).
REQ-013 SHALL have ports inc_thr, dec_thr (in, 1) and threshold (out, signed ACC_W).
REQ-014 SHALL have ports score (out, signed ACC_W) and detected (out, 1); ACC_W = DATA_W + WEIGHT_W + 4.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, DONE; busy = state != IDLE.
REQ-016 In IDLE, start high SHALL latch base_addr, clear accumulator and issue counter, go to ISSUE; start while busy SHALL be ignored.
REQ-017 In ISSUE, each cycle SHALL drive rd_en=1, rd_addr=(base+offset[k]) mod 2^ADDR_W for k=0..N_POINTS-1, then go to DRAIN.
REQ-018 A RD_LATENCY-deep valid/index pipeline SHALL tag returning data; each tagged data_in SHALL add sign-extended data_in * weight[k] to the accumulator.
REQ-019 DRAIN SHALL hold rd_en=0 until the last tagged sample is accumulated, then go to DONE.
REQ-020 DONE SHALL, for one cycle, assert done, register score=accumulator and detected=(score > threshold, signed), then return to IDLE.
REQ-021 Latency: start sampled at cycle t SHALL give rd_addr k at t+1+k and done at t+N_POINTS+RD_LATENCY+1.
REQ-022 score and detected SHALL hold their value until the next DONE.
REQ-023 cfg_we SHALL update the table only in IDLE; cfg_we while busy or with cfg_idx >= N_POINTS SHALL be ignored.
REQ-024 A weight of 0 SHALL still issue a read but contribute nothing.
REQ-025 Threshold adjustments SHALL apply only in IDLE, saturating at +/-(2^(ACC_W-1)-1); inc_thr and dec_thr together SHALL leave threshold unchanged.

Reset
REQ-026 rst_n low at a clock edge SHALL force IDLE, busy=0, done=0, rd_en=0, rd_addr=0, score=0, detected=0, threshold=THR_INIT, all offsets and weights 0, accumulator and pipeline cleared, including mid-operation with no done pulse.

Configuration
REQ-027 With macro HAAR_THR_ADJUST_EN defined, REQ-025 adjustment logic SHALL be present.
REQ-028 Without HAAR_THR_ADJUST_EN, threshold SHALL be constant THR_INIT and inc_thr/dec_thr SHALL be ignored.

Structure
REQ-029 Package haar_pkg SHALL hold the state encoding, ACC_W derivation function and default width constants.
REQ-030 Sub-module haar_rd_pipe SHALL implement the RD_LATENCY valid/index shift pipeline.

Verification
REQ-031 Defaults, weights {+1,-1,-1,+1,-2,+2,+2,-2} (three-rectangle), data_in = 10*(k+1) per point -> score = 0, detected=0, done at start+12.
REQ-032 base_addr=0x7FF0, offset 0x20 -> rd_addr=0x0010 (wrap).
REQ-033 start asserted again during ISSUE -> ignored, exactly one done pulse.
REQ-034 With HAAR_THR_ADJUST_EN, 3 inc_thr pulses in IDLE -> threshold=800; simultaneous inc/dec -> 800 unchanged; without the macro -> stays 500.
REQ-035 rst_n low at 2nd ISSUE cycle -> next cycle busy=0, rd_en=0, no done, table cleared.
REQ-036 N_POINTS=4, RD_LATENCY=1, weights all +1, data 100 each -> score=400, detected=0 at threshold 500, done at start+6.
